// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: emits counted frames of (seed + frame + beat) data
// with tlast on the final beat and tuser marking bad frames.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [LEN_WIDTH-1:0]  cfg_gap,
    input  logic [LEN_WIDTH-1:0]  cfg_count,
    input  logic                  cfg_bad,
    input  logic                  cfg_stop,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  frames_sent,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  gap_q, gap_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  bad_q, bad_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [LEN_WIDTH-1:0]  frames_q, frames_d;
    logic                  stop_seen_q, stop_seen_d;
    logic                  done_q, done_d;

    logic                  last_beat;
    logic                  handshake;
    logic [LEN_WIDTH-1:0]  frames_inc;

    // Valid/ready: a beat transfers on a rising edge where tvalid && tready;
    // while tvalid is high and tready low, tdata/tlast/tuser hold and tvalid never drops.
    assign last_beat  = (beat_q == len_q - LEN_WIDTH'(1));
    assign handshake  = m_axis_tvalid && m_axis_tready;
    assign frames_inc = frames_q + LEN_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            gap_q       <= '0;
            count_q     <= '0;
            seed_q      <= '0;
            bad_q       <= 1'b0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            frames_q    <= '0;
            stop_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            seed_q      <= seed_d;
            bad_q       <= bad_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            frames_q    <= frames_d;
            stop_seen_q <= stop_seen_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        gap_d       = gap_q;
        count_d     = count_q;
        seed_d      = seed_q;
        bad_d       = bad_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        frames_d    = frames_q;
        stop_seen_d = stop_seen_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    // A zero length still yields a single-beat frame.
                    len_d    = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
                    gap_d    = cfg_gap;
                    count_d  = cfg_count;
                    seed_d   = cfg_seed;
                    bad_d    = cfg_bad;
                    beat_d   = '0;
                    frames_d = '0;
                    if (cfg_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (last_beat) begin
                        frames_d = frames_inc;
                        beat_d   = '0;
                        if ((frames_inc == count_q) || cfg_stop) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d     = ST_GAP;
                            gap_cnt_d   = '0;
                            stop_seen_d = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_GAP: begin
                stop_seen_d = stop_seen_q | cfg_stop;
                if (gap_cnt_q == gap_q - LEN_WIDTH'(1)) begin
                    if (stop_seen_q || cfg_stop) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + LEN_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The completed-frame count doubles as the index of the frame being sent.
    assign m_axis_tvalid = (state_q == ST_SEND);
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign m_axis_tdata  = m_axis_tvalid
                         ? (seed_q + DATA_WIDTH'(frames_q) + DATA_WIDTH'(beat_q))
                         : '0;
    assign m_axis_tuser  = (m_axis_tlast && bad_q) ? {USER_WIDTH{1'b1}} : '0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign frames_sent   = frames_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: table of run configurations checked beat by beat
// against an expected queue, plus hand-written reset and stop sequences.
module tb_axis_frame_gen;

  localparam int DW = 8;
  localparam int UW = 1;
  localparam int LW = 16;
  localparam int BW = DW + UW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [DW-1:0] cfg_seed = '0;
  logic [LW-1:0] cfg_gap = '0;
  logic [LW-1:0] cfg_count = '0;
  logic          cfg_bad = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          busy;
  logic          done;
  logic [LW-1:0] frames_sent;
  logic [1:0]    dbg_state;

  axis_frame_gen #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_len       (cfg_len),
    .cfg_seed      (cfg_seed),
    .cfg_gap       (cfg_gap),
    .cfg_count     (cfg_count),
    .cfg_bad       (cfg_bad),
    .cfg_stop      (cfg_stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done),
    .frames_sent   (frames_sent),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [BW-1:0] exp_q[$];

  // monitor state
  int          done_cnt = 0;
  int          frames_hs = 0;
  int          beats_in_frame = 0;
  int          idle_cnt = 0;
  int          cur_gap = 0;
  int          cur_mode = 0;
  bit          gap_track = 0;
  bit          prev_stall = 0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] cur_beat;

  assign cur_beat = {m_axis_tlast, m_axis_tuser, m_axis_tdata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      gap_track = 0;
      prev_stall = 0;
      beats_in_frame = 0;
    end else begin
      if (done) begin
        done_cnt++;
        if (gap_track) begin
          check("idle_before_done", 64'(idle_cnt), 64'((cur_mode == 2) ? cur_gap : 0));
          gap_track = 0;
        end
      end
      if (prev_stall) begin
        check("stall_hold", {m_axis_tvalid, cur_beat}, {1'b1, prev_beat});
      end
      prev_stall = 0;
      if (m_axis_tvalid) begin
        if (gap_track) begin
          check("gap_len", 64'(idle_cnt), 64'(cur_gap));
          gap_track = 0;
        end
        if (m_axis_tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got %0h expected none", cur_beat);
          end else begin
            check("beat", 64'(cur_beat), 64'(exp_q.pop_front()));
          end
          beats_in_frame++;
          if (m_axis_tlast) begin
            frames_hs++;
            beats_in_frame = 0;
            gap_track = 1;
            idle_cnt = 0;
          end
        end else begin
          prev_stall = 1;
          prev_beat = cur_beat;
        end
      end else if (gap_track) begin
        idle_cnt++;
      end
    end
  end

  // mode: 0 run to count, 1 raise stop mid-frame (stop_at-1), 2 raise stop in gap after frame stop_at-1
  typedef struct {
    int len;
    int seed;
    int gap;
    int count;
    bit bad;
    bit rnd;
    int mode;
    int stop_at;
    int exp_fs;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int el;
    int nf;
    int cyc;
    logic [DW-1:0] d;
    el = (v.len == 0) ? 1 : v.len;
    nf = (v.mode != 0) ? v.stop_at : v.count;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < el; k++) begin
        d = DW'(v.seed + f + k);
        exp_q.push_back({(k == el - 1), ((k == el - 1) && v.bad), d});
      end
    end
    cur_gap = v.gap;
    cur_mode = v.mode;
    done_cnt = 0;
    frames_hs = 0;

    @(posedge clk); #1;
    cfg_len = LW'(v.len);
    cfg_seed = DW'(v.seed);
    cfg_gap = LW'(v.gap);
    cfg_count = LW'(v.count);
    cfg_bad = v.bad;
    cfg_stop = 1'b0;
    cfg_start = 1'b1;
    m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    // scrambled config must not affect the run in progress
    cfg_len = LW'($urandom_range(0, 9));
    cfg_seed = DW'($urandom_range(0, 255));
    cfg_gap = LW'($urandom_range(0, 5));
    cfg_count = LW'($urandom_range(0, 9));
    cfg_bad = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("start_latency", {busy, m_axis_tvalid, done},
          (v.count == 0) ? 3'b001 : 3'b110);

    for (cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
      @(posedge clk); #1;
      m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.mode == 1 && frames_hs == v.stop_at - 1 && beats_in_frame >= 1) cfg_stop = 1'b1;
      if (v.mode == 2 && frames_hs == v.stop_at && gap_track && !m_axis_tvalid) cfg_stop = 1'b1;
    end
    check("done_seen", 64'(done_cnt > 0), 64'd1);
    cfg_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("frames_sent", 64'(frames_sent), 64'(v.exp_fs));
    check("end_idle", {busy, m_axis_tvalid, dbg_state}, 4'b0000);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic reset_mid_frame();
    vec_t v;
    logic [DW-1:0] d;
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 3; k++) begin
        d = DW'(8'h20 + f + k);
        exp_q.push_back({(k == 2), 1'b1 & 1'b0, d});
      end
    cur_gap = 0;
    cur_mode = 0;
    @(posedge clk); #1;
    cfg_len = 3; cfg_seed = 8'h20; cfg_gap = 0; cfg_count = 5; cfg_bad = 0;
    m_axis_tready = 1'b1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_frames", 64'(frames_sent), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, done},
          '0);
    check("async_reset_frames", 64'(frames_sent), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {m_axis_tvalid, busy, done, dbg_state}, 5'b00000);
    check("post_reset_frames", 64'(frames_sent), 64'd0);
    v = '{len: 3, seed: 8'h20, gap: 0, count: 1, bad: 0, rnd: 0, mode: 0, stop_at: 0, exp_fs: 1};
    run_vec(v);
  endtask

  initial begin
    //          len  seed  gap cnt bad rnd mode stop exp_fs
    vecs[0] = '{4,   'h10, 0,  2,  0,  0,  0,   0,   2};
    vecs[1] = '{3,   'h20, 2,  2,  1,  0,  0,   0,   2};
    vecs[2] = '{4,   'h10, 0,  2,  0,  1,  0,   0,   2};
    vecs[3] = '{4,   'hFE, 0,  1,  0,  0,  0,   0,   1};
    vecs[4] = '{0,   'h33, 0,  1,  0,  0,  0,   0,   1};
    vecs[5] = '{5,   'h44, 0,  0,  0,  0,  0,   0,   0};
    vecs[6] = '{5,   'h40, 1,  5,  0,  1,  1,   2,   2};
    vecs[7] = '{6,   'h80, 3,  3,  1,  1,  0,   0,   3};
    vecs[8] = '{3,   'h05, 3,  4,  0,  1,  2,   2,   2};

    rst = 1'b0;
    #1;
    check("reset_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, done},
          '0);
    check("reset_frames", 64'(frames_sent), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {m_axis_tvalid, busy, done, dbg_state}, 5'b00000);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // start while busy is ignored: a second pulse mid-run must not restart the frame numbering
    begin
      vec_t v;
      v = '{len: 4, seed: 'h60, gap: 0, count: 3, bad: 0, rnd: 0, mode: 0, stop_at: 0, exp_fs: 3};
      fork
        run_vec(v);
        begin
          repeat (5) @(posedge clk);
          #2 cfg_start = 1'b1;
          @(posedge clk); #2 cfg_start = 1'b0;
        end
      join
    end

    reset_mid_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
